// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: valid/ready input, registered output stage, one-entry skid buffer.
// Optional macro IMM_GEN_PIPE_ZICSR_EN adds CSR-immediate decode and the zimm output.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
`ifdef IMM_GEN_PIPE_ZICSR_EN
  output logic [4:0]       zimm,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge.
  // in_ready is a function of registered state only (skid empty), never of out_ready.

  localparam int EW = XLEN + 4;  // {illegal, fmt, imm}

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] imm32;
  logic [2:0]  dec_fmt;
  logic        dec_ill;
  logic [EW-1:0] dec_entry;

  logic [EW-1:0]    out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_full_q, skid_full_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             in_fire, out_fire;

  assign op = inst[6:0];
  assign f3 = inst[14:12];

  // Every immediate is formed at 32 bits first, then sign-extended to XLEN.
  always_comb begin
    imm32   = 32'd0;
    dec_fmt = 3'd7;
    dec_ill = 1'b1;
    case (op)
      7'b0000011, 7'b1100111: begin
        imm32 = {{20{inst[31]}}, inst[31:20]};
        dec_fmt = 3'd1; dec_ill = 1'b0;
      end
      7'b0010011: begin
        dec_fmt = 3'd1; dec_ill = 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101)
          imm32 = (XLEN == 64) ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
        else
          imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt = 3'd1; dec_ill = 1'b0;
          if (f3 == 3'b001 || f3 == 3'b101)
            imm32 = {27'd0, inst[24:20]};
          else
            imm32 = {{20{inst[31]}}, inst[31:20]};
        end
      end
      7'b0100011: begin
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        dec_fmt = 3'd2; dec_ill = 1'b0;
      end
      7'b1100011: begin
        imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        dec_fmt = 3'd3; dec_ill = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        imm32 = {inst[31:12], 12'd0};
        dec_fmt = 3'd4; dec_ill = 1'b0;
      end
      7'b1101111: begin
        imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        dec_fmt = 3'd5; dec_ill = 1'b0;
      end
      7'b1110011: begin
        dec_fmt = 3'd0; dec_ill = 1'b0;
`ifdef IMM_GEN_PIPE_ZICSR_EN
        if (f3 != 3'b000) begin
          imm32 = {20'd0, inst[31:20]};
          dec_fmt = 3'd1;
        end
`endif
      end
      7'b0110011, 7'b0001111: begin
        dec_fmt = 3'd0; dec_ill = 1'b0;
      end
      7'b0111011: begin
        if (XLEN == 64) begin
          dec_fmt = 3'd0; dec_ill = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign dec_entry = {dec_ill, dec_fmt, {(XLEN-31){imm32[31]}}, imm32[30:0]};

  assign in_ready = ~skid_full_q;
  assign in_fire  = in_valid & ~skid_full_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (out_fire && xfer_cnt_q != {CNT_W{1'b1}})
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = dec_entry;
      end
    end else if (in_fire) begin
      skid_d      = dec_entry;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

`ifdef IMM_GEN_PIPE_ZICSR_EN
  // zimm rides alongside the main entry through the same output/skid slots.
  logic [4:0] zimm_q, zimm_d, zskid_q, zskid_d;

  always_comb begin
    zimm_d  = zimm_q;
    zskid_d = zskid_q;
    if (!flush) begin
      if (!out_valid_q || out_ready) begin
        if (skid_full_q)  zimm_d = zskid_q;
        else if (in_fire) zimm_d = inst[19:15];
      end else if (in_fire) begin
        zskid_d = inst[19:15];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zimm_q  <= '0;
      zskid_q <= '0;
    end else begin
      zimm_q  <= zimm_d;
      zskid_q <= zskid_d;
    end
  end

  assign zimm = zimm_q;
`endif

  assign out_valid = out_valid_q;
  assign illegal   = out_q[EW-1];
  assign fmt       = out_q[EW-2:EW-4];
  assign imm       = out_q[XLEN-1:0];
  assign xfer_cnt  = xfer_cnt_q;

endmodule
